// File: rtl/conv_relu_pool_if.sv
// rtl/conv_relu_pool_if.sv - conv-result input stream and pooled output stream of conv_relu_pool
interface conv_relu_pool_if #(
  parameter int WIDTH = 9
);
  logic                 in_valid;
  logic                 in_sof;
  logic [2*WIDTH-1:0]   in_data;
  logic                 out_valid;
  logic [2*WIDTH-1:0]   out_data;
  logic                 frame_done;

  modport master (
    output in_valid, in_sof, in_data,
    input  out_valid, out_data, frame_done
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output out_valid, out_data, frame_done
  );
endinterface

// File: rtl/conv_relu_pool.sv
// rtl/conv_relu_pool.sv - ReLU then 2x2/stride-2 max pooling over a raster-ordered conv-result stream
module conv_relu_pool #(
  parameter int WIDTH = 9,
  parameter int IMG_W = 26,
  parameter int IMG_H = 26
) (
  input  logic           clk,
  input  logic           rst,
  conv_relu_pool_if.slave bus
);
  localparam int DW = 2 * WIDTH;
  localparam int HW = IMG_W / 2;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int AW = (HW > 1) ? $clog2(HW) : 1;

  if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_img_w
    $error("conv_relu_pool: IMG_W must be even and >= 2");
  end
  if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_img_h
    $error("conv_relu_pool: IMG_H must be even and >= 2");
  end

  logic [CW-1:0] col, eff_col;
  logic [RW-1:0] row, eff_row;
  logic [DW-1:0] hold;
  logic [DW-1:0] relu, pair_max, lb_rd, pool;
  logic [AW-1:0] lb_idx;
  logic          last_col, last_row;
  logic          emit;
  logic [DW-1:0] linebuf [HW];

  // A start-of-frame beat is taken as (0,0) whatever the counters say.
  always_comb begin
    eff_col  = bus.in_sof ? '0 : col;
    eff_row  = bus.in_sof ? '0 : row;
    relu     = bus.in_data[DW-1] ? '0 : bus.in_data;
    pair_max = (hold > relu) ? hold : relu;
    lb_idx   = AW'(eff_col >> 1);
    lb_rd    = linebuf[lb_idx];
    pool     = (lb_rd > pair_max) ? lb_rd : pair_max;
    last_col = (eff_col == CW'(IMG_W - 1));
    last_row = (eff_row == RW'(IMG_H - 1));
    emit     = bus.in_valid && eff_col[0] && eff_row[0];
  end

  // Even rows park the horizontal pair max; the odd row below reads it back.
  always_ff @(posedge clk) begin
    if (bus.in_valid && eff_col[0] && !eff_row[0]) begin
      linebuf[lb_idx] <= pair_max;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col            <= '0;
      row            <= '0;
      hold           <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.out_valid  <= emit;
      bus.frame_done <= emit && last_col && last_row;
      if (emit) begin
        bus.out_data <= pool;
      end
      if (bus.in_valid) begin
        if (!eff_col[0]) begin
          hold <= relu;
        end
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : eff_row + 1'b1;
        end else begin
          col <= eff_col + 1'b1;
          row <= eff_row;
        end
      end
    end
  end
endmodule

// File: tb/tb_conv_relu_pool.sv
// tb/tb_conv_relu_pool.sv - self-checking bench for conv_relu_pool (4x4, 4x2 and 26x26 instances)
module tb_conv_relu_pool;
  localparam int DW = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [DW-1:0] in_data = '0;

  always #5 clk = ~clk;

  conv_relu_pool_if #(.WIDTH(9)) if44 ();
  conv_relu_pool_if #(.WIDTH(9)) if42 ();
  conv_relu_pool_if #(.WIDTH(9)) if26 ();

  assign if44.in_valid = in_valid;
  assign if44.in_sof   = in_sof;
  assign if44.in_data  = in_data;
  assign if42.in_valid = in_valid;
  assign if42.in_sof   = in_sof;
  assign if42.in_data  = in_data;
  assign if26.in_valid = in_valid;
  assign if26.in_sof   = in_sof;
  assign if26.in_data  = in_data;

  conv_relu_pool #(.WIDTH(9), .IMG_W(4),  .IMG_H(4))  dut44 (.clk(clk), .rst(rst), .bus(if44));
  conv_relu_pool #(.WIDTH(9), .IMG_W(4),  .IMG_H(2))  dut42 (.clk(clk), .rst(rst), .bus(if42));
  conv_relu_pool #(.WIDTH(9), .IMG_W(26), .IMG_H(26)) dut26 (.clk(clk), .rst(rst), .bus(if26));

  typedef struct packed {
    logic [DW-1:0] d;
    logic          fd;
    logic [31:0]   b;
  } obs_t;

  obs_t          obs_q[$];
  int            sel = 0;
  int            beat_cnt = 0;
  logic          mon_v, mon_fd;
  logic [DW-1:0] mon_d;
  int            n_tests = 0;
  int            n_fail = 0;

  always_comb begin
    mon_v  = if44.out_valid;
    mon_fd = if44.frame_done;
    mon_d  = if44.out_data;
    case (sel)
      1: begin mon_v = if42.out_valid; mon_fd = if42.frame_done; mon_d = if42.out_data; end
      2: begin mon_v = if26.out_valid; mon_fd = if26.frame_done; mon_d = if26.out_data; end
      default: ;
    endcase
  end

  always @(posedge clk) if (!rst && in_valid) beat_cnt++;

  always @(negedge clk) if (mon_v) obs_q.push_back('{d: mon_d, fd: mon_fd, b: beat_cnt});

  task automatic check(input string what, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", what, act, exp);
    end
  endtask

  task automatic beat(input bit v, input bit s, input int d);
    @(posedge clk);
    #1;
    in_valid = v;
    in_sof   = s;
    in_data  = DW'(d);
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b0, 1'b0, 0);
  endtask

  task automatic send_frame(input int fr[$], input bit with_sof, input bit gaps);
    foreach (fr[i]) begin
      if (gaps)
        for (int g = 0; g < 3 && $urandom_range(0, 99) < 30; g++)
          beat(1'b0, 1'($urandom_range(0, 1)), int'($urandom));
      beat(1'b1, with_sof && (i == 0), fr[i]);
    end
  endtask

  // Golden reference: every 2x2 window in raster order, max of the four values floored at zero.
  function automatic void pool_model(input int w, input int h, input int fr[$], output int exp[$]);
    exp = {};
    for (int pr = 0; pr < h / 2; pr++) begin
      for (int pc = 0; pc < w / 2; pc++) begin
        int m = 0;
        for (int dy = 0; dy < 2; dy++)
          for (int dx = 0; dx < 2; dx++)
            if (fr[(2 * pr + dy) * w + 2 * pc + dx] > m) m = fr[(2 * pr + dy) * w + 2 * pc + dx];
        exp.push_back(m);
      end
    end
  endfunction

  task automatic compare_obs(input string tag, input int exp[$], input int per_frame);
    check($sformatf("%s count", tag), obs_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s[%0d] data", tag, i), obs_q[i].d, exp[i]);
      check($sformatf("%s[%0d] frame_done", tag, i), obs_q[i].fd, ((i + 1) % per_frame) == 0);
    end
  endtask

  typedef struct {
    int                  sel;
    int                  n_in;
    int                  n_exp;
    logic [15:0][DW-1:0] din;
    logic [3:0][DW-1:0]  dexp;
    logic [3:0][DW-1:0]  dbeat;
  } vec_t;

  vec_t tv[5];

  function automatic logic [3:0][DW-1:0] r4(input int a, input int b, input int c, input int d);
    logic [3:0][DW-1:0] r;
    r[0] = DW'(a); r[1] = DW'(b); r[2] = DW'(c); r[3] = DW'(d);
    return r;
  endfunction

  function automatic vec_t mk(input int s, input int ni, input int ne, input logic [15:0][DW-1:0] di,
                              input logic [3:0][DW-1:0] de, input logic [3:0][DW-1:0] db);
    vec_t v;
    v.sel = s; v.n_in = ni; v.n_exp = ne; v.din = di; v.dexp = de; v.dbeat = db;
    return v;
  endfunction

  int ramp[$], ramp2[$], rev[$], junk[$], fra[$], frb[$];
  int exp_q[$], ea[$], eb[$];
  int base;

  initial begin
    tv[0] = mk(0, 16, 4, {r4(12, 13, 14, 15), r4(8, 9, 10, 11), r4(4, 5, 6, 7), r4(0, 1, 2, 3)},
               r4(5, 7, 13, 15), r4(6, 8, 14, 16));
    tv[1] = mk(1, 8, 2, {r4(0, 0, 0, 0), r4(0, 0, 0, 0), r4(-7, 2, -4, -9), r4(-1, -5, -3, -2)},
               r4(2, 0, 0, 0), r4(6, 8, 0, 0));
    tv[2] = mk(1, 8, 2, {r4(0, 0, 0, 0), r4(0, 0, 0, 0), r4(4, -4, 10, 10), r4(4, 4, 10, -3)},
               r4(4, 10, 0, 0), r4(6, 8, 0, 0));
    tv[3] = mk(1, 8, 2, {r4(0, 0, 0, 0), r4(0, 0, 0, 0), r4(1, 2, 3, 4), r4(100, -2, 3, 131071)},
               r4(100, 131071, 0, 0), r4(6, 8, 0, 0));
    tv[4] = mk(0, 16, 4, {r4(-12, -13, -14, -15), r4(-8, -9, -10, -11), r4(-4, -5, -6, -7),
               r4(-131072, -1, -2, -3)}, r4(0, 0, 0, 0), r4(6, 8, 14, 16));

    for (int i = 0; i < 16; i++) begin
      ramp.push_back(i);
      ramp2.push_back(i + 16);
      rev.push_back(15 - i);
    end
    for (int i = 0; i < 5; i++) junk.push_back(100 + i);

    // Reset state of every instance
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset out_valid 4x4", if44.out_valid, 0);
    check("reset out_data 4x4", if44.out_data, 0);
    check("reset frame_done 4x4", if44.frame_done, 0);
    check("reset out_valid 4x2", if42.out_valid, 0);
    check("reset out_data 4x2", if42.out_data, 0);
    check("reset out_valid 26x26", if26.out_valid, 0);
    check("reset out_data 26x26", if26.out_data, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Table-driven single frames
    for (int t = 0; t < 5; t++) begin
      sel = tv[t].sel;
      obs_q = {};
      base = beat_cnt;
      for (int i = 0; i < tv[t].n_in; i++) beat(1'b1, i == 0, int'(tv[t].din[i]));
      idle(3);
      check($sformatf("vec%0d count", t), obs_q.size(), tv[t].n_exp);
      for (int k = 0; k < tv[t].n_exp && k < obs_q.size(); k++) begin
        check($sformatf("vec%0d[%0d] data", t, k), obs_q[k].d, tv[t].dexp[k]);
        check($sformatf("vec%0d[%0d] latency", t, k), longint'(obs_q[k].b) - base, tv[t].dbeat[k]);
        check($sformatf("vec%0d[%0d] frame_done", t, k), obs_q[k].fd, k == tv[t].n_exp - 1);
      end
    end

    // Mid-frame resync: a partial frame is abandoned by a new in_sof
    sel = 0;
    obs_q = {};
    send_frame(junk, 1'b1, 1'b0);
    send_frame(ramp, 1'b1, 1'b0);
    idle(3);
    pool_model(4, 4, ramp, exp_q);
    compare_obs("resync", exp_q, 4);

    // Back-to-back frames, no idle between them
    obs_q = {};
    send_frame(ramp, 1'b1, 1'b0);
    send_frame(ramp2, 1'b1, 1'b0);
    idle(3);
    pool_model(4, 4, ramp, ea);
    pool_model(4, 4, ramp2, eb);
    exp_q = {ea, eb};
    compare_obs("b2b", exp_q, 4);

    // Reset mid-frame, then a fresh frame without in_sof
    obs_q = {};
    for (int i = 0; i < 10; i++) beat(1'b1, i == 0, ramp[i]);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midreset out_valid", if44.out_valid, 0);
    check("midreset out_data", if44.out_data, 0);
    check("midreset frame_done", if44.frame_done, 0);
    rst = 1'b0;
    obs_q = {};
    send_frame(rev, 1'b0, 1'b0);
    idle(3);
    pool_model(4, 4, rev, exp_q);
    compare_obs("postreset", exp_q, 4);

    // Random 26x26 frames with idle gaps
    sel = 2;
    obs_q = {};
    for (int i = 0; i < 26 * 26; i++) begin
      fra.push_back(int'($urandom_range(0, 262143)) - 131072);
      frb.push_back(int'($urandom_range(0, 262143)) - 131072);
    end
    send_frame(fra, 1'b1, 1'b1);
    send_frame(frb, 1'b1, 1'b1);
    idle(4);
    pool_model(26, 26, fra, ea);
    pool_model(26, 26, frb, eb);
    exp_q = {ea, eb};
    compare_obs("rand26", exp_q, 169);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
